dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the shared data-memory arbiter: two request ports plus the shared response signals.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          ack0, ack1;
  logic          err0, err1;
  logic [31:0]   rdata;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1, rdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access runs IDLE -> ACCESS -> RESP, one cycle per state.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           Memwrite,
  output logic           Memread,
  output logic [AW-1:0]  read_address,
  output logic [31:0]    write_data,
  input  logic [31:0]    Memdata_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_ptr;
  logic          r_port;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          w_any_req;
  logic          w_grant;
  logic          w_inrange;

  assign w_any_req = bus.req0 | bus.req1;
  // Contention goes to the preferred port; otherwise whoever is requesting wins.
  assign w_grant   = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
  assign w_inrange = (r_addr < AW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_port  <= w_grant;
            r_we    <= w_grant ? bus.we1    : bus.we0;
            r_addr  <= w_grant ? bus.addr1  : bus.addr0;
            r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: r_rdata <= (~r_we & w_inrange) ? Memdata_out : 32'h0;
        RESP:   r_ptr   <= ~r_port;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign Memwrite     = (r_state == ACCESS) &  r_we & w_inrange;
  assign Memread      = (r_state == ACCESS) & ~r_we & w_inrange;
  assign read_address = r_addr;
  assign write_data   = r_wdata;

  assign bus.ack0  = (r_state == RESP) & ~r_port;
  assign bus.ack1  = (r_state == RESP) &  r_port;
  assign bus.err0  = bus.ack0 & ~w_inrange;
  assign bus.err1  = bus.ack1 & ~w_inrange;
  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected acks and memory strobes, monitors check them.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Memwrite, Memread;
  logic [AW-1:0] read_address;
  logic [31:0]   write_data;
  logic [31:0]   Memdata_out;

  dmem_arbiter_if #(.AW(AW)) bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .Memwrite     (Memwrite),
    .Memread      (Memread),
    .read_address (read_address),
    .write_data   (write_data),
    .Memdata_out  (Memdata_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  assign Memdata_out = (read_address < DEPTH) ? mem[read_address[5:0]] : 32'h0;
  always @(posedge clk) if (Memwrite) mem[read_address[5:0]] <= write_data;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          gap;
  } ack_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stb_t;

  ack_t ackq[$];
  stb_t stbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_ack_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (!rst && (bus.ack0 || bus.ack1)) begin
      ack_t e;
      chk("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
      chk("strobe_in_resp", {30'd0, Memwrite, Memread}, 32'd0);
      if (ackq.size() == 0) begin
        chk("unexpected_ack", {31'd0, bus.ack1}, 32'hFFFF_FFFF);
      end else begin
        e = ackq.pop_front();
        chk("ack_port",  {31'd0, bus.ack1}, {31'd0, e.port});
        chk("ack_err",   {31'd0, (e.port ? bus.err1 : bus.err0)}, {31'd0, e.err});
        chk("ack_rdata", bus.rdata, e.rdata);
        if (e.gap != 0) chk("ack_gap", cyc - last_ack_cyc, e.gap);
      end
      last_ack_cyc = cyc;
    end
  end

  // Memory strobe monitor
  always @(negedge clk) begin
    if (!rst && (Memwrite || Memread)) begin
      stb_t s;
      chk("strobe_exclusive", {31'd0, Memwrite & Memread}, 32'd0);
      if (stbq.size() == 0) begin
        chk("unexpected_strobe", read_address, 32'hFFFF_FFFF);
      end else begin
        s = stbq.pop_front();
        chk("strobe_we",   {31'd0, Memwrite}, {31'd0, s.we});
        chk("strobe_addr", read_address, s.addr);
        if (s.we) chk("strobe_wdata", write_data, s.wdata);
      end
    end
  end

  function automatic ack_t mk_ack(input logic p, input logic e, input logic [31:0] d, input int g);
    ack_t a;
    a.port = p; a.err = e; a.rdata = d; a.gap = g;
    return a;
  endfunction

  function automatic stb_t mk_stb(input logic w, input logic [31:0] a, input logic [31:0] d);
    stb_t s;
    s.we = w; s.addr = a; s.wdata = d;
    return s;
  endfunction

  task automatic drive(input logic p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic wait_ack(input logic p);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (p ? bus.ack1 : bus.ack0) seen = 1'b1;
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
    drive(p, 1'b1, w, a, d);
    wait_ack(p);
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic contend(input int n);
    int got = 0;
    for (int i = 0; i < 10 * n && got < n; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) got++;
    end
    if (got != n) chk("contend_timeout", got, n);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ack"},   {30'd0, bus.ack0, bus.ack1}, 32'd0);
    chk({tag, "_err"},   {30'd0, bus.err0, bus.err1}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    chk({tag, "_strb"},  {30'd0, Memwrite, Memread}, 32'd0);
    chk({tag, "_raddr"}, read_address, 32'd0);
    chk({tag, "_wdata"}, write_data, 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[2] = 32'h22; mem[4] = 32'h44; mem[7] = 32'h5; mem[9] = 32'h99; mem[11] = 32'h11;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single write, port 0
    stbq.push_back(mk_stb(1'b1, 32'd3, 32'hA5A5_0001));
    ackq.push_back(mk_ack(1'b0, 1'b0, 32'h0, 0));
    single(1'b0, 1'b1, 32'd3, 32'hA5A5_0001);
    chk("mem3_written", mem[3], 32'hA5A5_0001);

    // Single read, port 1
    stbq.push_back(mk_stb(1'b0, 32'd7, 32'h0));
    ackq.push_back(mk_ack(1'b1, 1'b0, 32'h5, 0));
    single(1'b1, 1'b0, 32'd7, 32'h0);

    // Contention: pointer is back on port 0, expect 0,1,0,1 three cycles apart
    for (int i = 0; i < 2; i++) begin
      stbq.push_back(mk_stb(1'b1, 32'd10, 32'h100));
      ackq.push_back(mk_ack(1'b0, 1'b0, 32'h0, (i == 0) ? 0 : 3));
      stbq.push_back(mk_stb(1'b0, 32'd11, 32'h0));
      ackq.push_back(mk_ack(1'b1, 1'b0, 32'h11, 3));
    end
    drive(1'b0, 1'b1, 1'b1, 32'd10, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'd11, 32'h0);
    contend(4);
    chk("mem10_written", mem[10], 32'h100);

    // Out-of-range read: no strobe, err set
    ackq.push_back(mk_ack(1'b0, 1'b1, 32'h0, 0));
    single(1'b0, 1'b0, 32'd64, 32'h0);

    // Reset during ACCESS of a write to addr 2
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd2, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 outputs_zero("midrst");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mem2_kept", mem[2], 32'h22);
    @(negedge clk);
    stbq.push_back(mk_stb(1'b0, 32'd7, 32'h0));
    ackq.push_back(mk_ack(1'b0, 1'b0, 32'h5, 0));
    stbq.push_back(mk_stb(1'b0, 32'd3, 32'h0));
    ackq.push_back(mk_ack(1'b1, 1'b0, 32'hA5A5_0001, 3));
    drive(1'b0, 1'b1, 1'b0, 32'd7, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd3, 32'h0);
    contend(2);

    // Address changes mid-transaction are ignored
    @(negedge clk);
    stbq.push_back(mk_stb(1'b0, 32'd4, 32'h0));
    ackq.push_back(mk_ack(1'b0, 1'b0, 32'h44, 0));
    drive(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    bus.addr0 = 32'd9;
    wait_ack(1'b0);
    chk("stable_raddr_resp", read_address, 32'd4);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("stable_raddr_idle", read_address, 32'd4);

    repeat (4) @(negedge clk);
    chk("ackq_drained", ackq.size(), 32'd0);
    chk("stbq_drained", stbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
